cpc_ram_bank_ctrl: RTL and testbench

//  Clocked banking controller for the 1MB CPC RAM expansion (two 512Kx8 SRAMs).
//  - Detects Z80 I/O writes to the RAM-config port 0x7Fxx/0x7Exx (A15=0, D7:D6=11) with a glitch filter.
//  - Latches the config byte and the A8 port select.
//  - Drives SRAM high address, per-chip selects and RAMDIS for the currently addressed 16K window.

---
 rtl/cpc_ram_pkg.sv | 45 ++++
 rtl/cpc_ram_port_fsm.sv | 95 +++++++++
 rtl/cpc_ram_bank_ctrl.sv | 95 +++++++++
 tb/tb_cpc_ram_bank_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpc_ram_pkg.sv
// Shared types, constants and the window/block map for the CPC RAM banking controller.
// Latency: n/a (package only; ext_map is purely combinational).
// Backpressure: n/a.
package cpc_ram_pkg;

  // Port-write FSM state encoding. Plain constants keep the encoding fixed
  // for anything downstream that probes the state register.
  typedef logic [1:0] port_state_t;
  localparam port_state_t ST_IDLE     = 2'd0;
  localparam port_state_t ST_FILTER   = 2'd1;
  localparam port_state_t ST_WAIT_REL = 2'd2;

  // Banking modes as written to D[2:0] of the config port.
  localparam logic [2:0] MODE_0 = 3'd0;
  localparam logic [2:0] MODE_1 = 3'd1;
  localparam logic [2:0] MODE_2 = 3'd2;
  localparam logic [2:0] MODE_3 = 3'd3;
  localparam logic [2:0] MODE_4 = 3'd4;
  localparam logic [2:0] MODE_5 = 3'd5;
  localparam logic [2:0] MODE_6 = 3'd6;
  localparam logic [2:0] MODE_7 = 3'd7;

  // Width of the filter counter; large enough for FILTER_CYCLES up to 4.
  localparam int CNT_W = 3;

  // Window/block map. Returns {ext, blk[1:0]}: ext=1 means the expansion
  // owns the 16K window 'win' and blk is the 16K block inside the 64K page.
  function automatic logic [2:0] ext_map(input logic [2:0] mode,
                                         input logic [1:0] win);
    logic [2:0] r;
    r = 3'b000;
    case (mode)
      MODE_0: r = 3'b000;
      // Mode 3 only remaps window 3 here; window 1 is handled by the host,
      // so the expansion must stay off the bus for it.
      MODE_1, MODE_3: if (win == 2'd3) r = {1'b1, 2'd3};
      MODE_2:         r = {1'b1, win};
      // Modes 4..7 map window 1 onto block (mode-4), i.e. mode[1:0].
      MODE_4, MODE_5, MODE_6, MODE_7: if (win == 2'd1) r = {1'b1, mode[1:0]};
      default:        r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpc_ram_port_fsm.sv
// Glitch-filtered detector for Z80 I/O writes to the RAM-config port (0x7Fxx/0x7Exx).
// Latency: commit asserts combinationally in the FILTER_CYCLES-th consecutive hit cycle.
// Backpressure: none; one commit per I/O cycle, further hits ignored until the strobe releases.
//
// Ports:
//   CLK, RESET_B   clock, synchronous active-low reset (FSM parks in WAIT_REL)
//   IOREQ_B, WR_B  Z80 I/O request and write strobe, active low
//   A15            CPU address bit 15 (must be 0 for a port hit)
//   d_hi           CPU data D[7:6] (must be 11 for a port hit)
//   commit         high in the cycle whose rising edge should latch the config
module cpc_ram_port_fsm
  import cpc_ram_pkg::*;
#(
  parameter int FILTER_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       IOREQ_B,
  input  logic       WR_B,
  input  logic       A15,
  input  logic [1:0] d_hi,
  output logic       commit
);

  localparam logic [CNT_W-1:0] FILT_N = CNT_W'(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  port_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hit;
  logic             strobe_rel;

  assign hit        = !IOREQ_B && !WR_B && !A15 && d_hi[1] && d_hi[0];
  assign strobe_rel = IOREQ_B || WR_B;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hit) begin
          if (ONE >= FILT_N) begin
            // Single-sample filter: commit on the very first hit.
            commit    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_WAIT_REL;
          end else begin
            cnt_nxt   = ONE;
            state_nxt = ST_FILTER;
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      ST_FILTER: begin
        if (hit) begin
          if (cnt + ONE >= FILT_N) begin
            commit    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_WAIT_REL;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end else begin
          // Hit dropped before the filter filled: treat as a glitch.
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_REL: begin
        // Only the strobes matter here, so data changes mid-cycle
        // (including D[7:6]) cannot retrigger a commit.
        cnt_nxt = '0;
        if (strobe_rel) state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_WAIT_REL;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      // Park in WAIT_REL so a strobe that straddles reset is never committed.
      state <= ST_WAIT_REL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/cpc_ram_bank_ctrl.sv
// Banking controller for the 1MB CPC RAM expansion (two 512Kx8 SRAMs).
// Latency: config visible on outputs 1 cycle after the commit edge; address/CS decode is combinational.
// Backpressure: none; the Z80 bus is never stalled.
//
// Ports:
//   CLK, RESET_B     Z80 clock, synchronous active-low reset
//   A15, A14, A8     CPU address bits (A15:A14 select the 16K window, A8 the SRAM on port write)
//   D                CPU data bus (config byte on port write)
//   IOREQ_B, WR_B    Z80 I/O request and write strobe, active low
//   MREQ_B           Z80 memory request, active low
//   ramadr_hi        SRAM A18:A14 = {page, blk} while the expansion owns the window, else 0
//   ramcs0_b/1_b     per-SRAM chip selects, active low
//   RAMDIS           high while the expansion owns the current window
//   cfg_q            {chip_sel, 0, page, mode} readback
//   cfg_wr           one-cycle pulse, coincident with the new config appearing on cfg_q
module cpc_ram_bank_ctrl
  import cpc_ram_pkg::*;
#(
  parameter int FILTER_CYCLES = 2,
  parameter int PAGE_BITS     = 3
) (
  input  logic                 CLK,
  input  logic                 RESET_B,
  input  logic                 A15,
  input  logic                 A14,
  input  logic                 A8,
  input  logic [7:0]           D,
  input  logic                 IOREQ_B,
  input  logic                 WR_B,
  input  logic                 MREQ_B,
  output logic [PAGE_BITS+1:0] ramadr_hi,
  output logic                 ramcs0_b,
  output logic                 ramcs1_b,
  output logic                 RAMDIS,
  output logic [7:0]           cfg_q,
  output logic                 cfg_wr
);

  logic                 commit;
  logic [2:0]           mode;
  logic [PAGE_BITS-1:0] page;
  logic                 chip_sel;
  logic [2:0]           map;
  logic                 ext;
  logic [1:0]           blk;
  logic                 mem_sel;

  cpc_ram_port_fsm #(
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_port_fsm (
    .CLK     (CLK),
    .RESET_B (RESET_B),
    .IOREQ_B (IOREQ_B),
    .WR_B    (WR_B),
    .A15     (A15),
    .d_hi    (D[7:6]),
    .commit  (commit)
  );

  // Config registers sample the bus on the commit edge; cfg_wr is the
  // registered commit so it lines up with the new value on cfg_q.
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      mode     <= MODE_0;
      page     <= '0;
      chip_sel <= 1'b0;
      cfg_wr   <= 1'b0;
    end else begin
      cfg_wr <= commit;
      if (commit) begin
        mode     <= D[2:0];
        page     <= D[3 +: PAGE_BITS];
        chip_sel <= A8;
      end
    end
  end

  // Window decode uses the registered config only, so a memory cycle that
  // overlaps a port write keeps the old mapping until the cycle after commit.
  assign map = ext_map(mode, {A15, A14});
  // Forced off while reset is held so the SRAMs are never selected before
  // the config registers have been cleared.
  assign ext = map[2] && RESET_B;
  assign blk = map[1:0];

  assign RAMDIS    = ext;
  assign ramadr_hi = ext ? {page, blk} : '0;

  assign mem_sel  = ext && !MREQ_B;
  assign ramcs0_b = !(mem_sel && !chip_sel);
  assign ramcs1_b = !(mem_sel &&  chip_sel);

  assign cfg_q = {chip_sel, 1'b0, 3'(page), mode};

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Directed self-checking bench for cpc_ram_bank_ctrl (FILTER_CYCLES=2, PAGE_BITS=3).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_cpc_ram_bank_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_B;
  logic       A15, A14, A8;
  logic [7:0] D;
  logic       IOREQ_B, WR_B, MREQ_B;
  logic [4:0] ramadr_hi;
  logic       ramcs0_b, ramcs1_b, RAMDIS;
  logic [7:0] cfg_q;
  logic       cfg_wr;

  int n_cmp = 0;
  int n_err = 0;

  cpc_ram_bank_ctrl #(
    .FILTER_CYCLES (2),
    .PAGE_BITS     (3)
  ) dut (
    .CLK       (CLK),
    .RESET_B   (RESET_B),
    .A15       (A15),
    .A14       (A14),
    .A8        (A8),
    .D         (D),
    .IOREQ_B   (IOREQ_B),
    .WR_B      (WR_B),
    .MREQ_B    (MREQ_B),
    .ramadr_hi (ramadr_hi),
    .ramcs0_b  (ramcs0_b),
    .ramcs1_b  (ramcs1_b),
    .RAMDIS    (RAMDIS),
    .cfg_q     (cfg_q),
    .cfg_wr    (cfg_wr)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Port write with strobes held for ncyc edges, then released.
  // Returns how many cycles cfg_wr was seen high.
  task automatic do_write(input logic a8, input logic [7:0] d, input int ncyc,
                          output int pulses);
    pulses  = 0;
    A15     = 1'b0;
    A8      = a8;
    D       = d;
    IOREQ_B = 1'b0;
    WR_B    = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (cfg_wr === 1'b1) pulses++;
    end
    IOREQ_B = 1'b1;
    WR_B    = 1'b1;
    step();
    if (cfg_wr === 1'b1) pulses++;
    step();
  endtask

  task automatic test_reset();
    RESET_B = 1'b0;
    MREQ_B  = 1'b0;
    A15 = 1'b1; A14 = 1'b1; A8 = 1'b0; D = 8'h00;
    IOREQ_B = 1'b1; WR_B = 1'b1;
    step();
    step();
    n_cmp++;
    if (ramcs0_b !== 1'b1 || ramcs1_b !== 1'b1) begin
      n_err++;
      $display("FAIL reset_cs: cs0=%b cs1=%b expected 1 1", ramcs0_b, ramcs1_b);
    end
    n_cmp++;
    if (cfg_q !== 8'h00) begin
      n_err++;
      $display("FAIL reset_cfg: got %h expected 00", cfg_q);
    end
    n_cmp++;
    if (RAMDIS !== 1'b0 || cfg_wr !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ramdis: RAMDIS=%b cfg_wr=%b expected 0 0", RAMDIS, cfg_wr);
    end
    RESET_B = 1'b1;
    step();
    n_cmp++;
    if (RAMDIS !== 1'b0 || ramcs0_b !== 1'b1 || ramcs1_b !== 1'b1 || ramadr_hi !== 5'b0) begin
      n_err++;
      $display("FAIL post_reset_mode0: RAMDIS=%b cs=%b%b adr=%b expected 0 11 00000",
               RAMDIS, ramcs0_b, ramcs1_b, ramadr_hi);
    end
  endtask

  task automatic test_filtered_write();
    int p;
    MREQ_B = 1'b1;
    do_write(1'b1, 8'hC5, 2, p);
    n_cmp++;
    if (p !== 1) begin
      n_err++;
      $display("FAIL filt_pulse: got %0d pulses expected 1", p);
    end
    n_cmp++;
    if (cfg_q !== 8'h85) begin
      n_err++;
      $display("FAIL filt_cfg: got %h expected 85", cfg_q);
    end
    MREQ_B = 1'b0; A15 = 1'b0; A14 = 1'b1;
    #1;
    n_cmp++;
    if (RAMDIS !== 1'b1 || ramadr_hi !== 5'b00001 || ramcs1_b !== 1'b0 || ramcs0_b !== 1'b1) begin
      n_err++;
      $display("FAIL filt_map: RAMDIS=%b adr=%b cs0=%b cs1=%b expected 1 00001 1 0",
               RAMDIS, ramadr_hi, ramcs0_b, ramcs1_b);
    end
    MREQ_B = 1'b1;
  endtask

  task automatic test_glitch();
    int p;
    do_write(1'b0, 8'hC0, 1, p);
    n_cmp++;
    if (p !== 0 || cfg_q !== 8'h85) begin
      n_err++;
      $display("FAIL glitch: pulses=%0d cfg=%h expected 0 85", p, cfg_q);
    end
  endtask

  task automatic test_long_strobe();
    int p;
    p = 0;
    A15 = 1'b0; A8 = 1'b0; D = 8'hC2;
    IOREQ_B = 1'b0; WR_B = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cfg_wr === 1'b1) p++;
      if (i == 1) D = 8'hC3;
    end
    IOREQ_B = 1'b1; WR_B = 1'b1;
    step();
    if (cfg_wr === 1'b1) p++;
    step();
    n_cmp++;
    if (p !== 1) begin
      n_err++;
      $display("FAIL long_pulse: got %0d pulses expected 1", p);
    end
    n_cmp++;
    if (cfg_q !== 8'h02) begin
      n_err++;
      $display("FAIL long_cfg: got %h expected 02", cfg_q);
    end
  endtask

  task automatic test_mode2_sweep();
    int p;
    logic [4:0] exp_adr [4];
    exp_adr[0] = 5'b11100; exp_adr[1] = 5'b11101;
    exp_adr[2] = 5'b11110; exp_adr[3] = 5'b11111;
    do_write(1'b0, 8'hFA, 2, p);
    n_cmp++;
    if (p !== 1 || cfg_q !== 8'h3A) begin
      n_err++;
      $display("FAIL m2_cfg: pulses=%0d cfg=%h expected 1 3a", p, cfg_q);
    end
    MREQ_B = 1'b0;
    for (int w = 0; w < 4; w++) begin
      {A15, A14} = 2'(w);
      #1;
      n_cmp++;
      if (ramadr_hi !== exp_adr[w] || ramcs0_b !== 1'b0 || ramcs1_b !== 1'b1 || RAMDIS !== 1'b1) begin
        n_err++;
        $display("FAIL m2_win%0d: adr=%b cs0=%b cs1=%b dis=%b expected %b 0 1 1",
                 w, ramadr_hi, ramcs0_b, ramcs1_b, RAMDIS, exp_adr[w]);
      end
    end
    MREQ_B = 1'b1;
  endtask

  // Remaining modes: only the listed window is external, each with its own block.
  task automatic test_map_modes();
    int p;
    logic [7:0] dv   [4];
    logic       a8v  [4];
    logic [7:0] cfgv [4];
    logic [1:0] winv [4];
    logic [4:0] adrv [4];
    dv[0] = 8'hC1; a8v[0] = 1'b1; cfgv[0] = 8'h81; winv[0] = 2'd3; adrv[0] = 5'b00011;
    dv[1] = 8'hD4; a8v[1] = 1'b0; cfgv[1] = 8'h14; winv[1] = 2'd1; adrv[1] = 5'b01000;
    dv[2] = 8'hDB; a8v[2] = 1'b0; cfgv[2] = 8'h1B; winv[2] = 2'd3; adrv[2] = 5'b01111;
    dv[3] = 8'hC7; a8v[3] = 1'b1; cfgv[3] = 8'h87; winv[3] = 2'd1; adrv[3] = 5'b00011;
    for (int m = 0; m < 4; m++) begin
      MREQ_B = 1'b1;
      do_write(a8v[m], dv[m], 2, p);
      n_cmp++;
      if (p !== 1 || cfg_q !== cfgv[m]) begin
        n_err++;
        $display("FAIL map%0d_cfg: pulses=%0d cfg=%h expected 1 %h", m, p, cfg_q, cfgv[m]);
      end
      MREQ_B = 1'b0;
      for (int w = 0; w < 4; w++) begin
        logic [1:0] wb;
        logic       exp_dis;
        wb = 2'(w);
        {A15, A14} = wb;
        #1;
        exp_dis = (wb == winv[m]);
        n_cmp++;
        if (RAMDIS !== exp_dis ||
            ramadr_hi !== (exp_dis ? adrv[m] : 5'b0) ||
            ramcs0_b !== !(exp_dis && !a8v[m]) ||
            ramcs1_b !== !(exp_dis && a8v[m])) begin
          n_err++;
          $display("FAIL map%0d_win%0d: dis=%b adr=%b cs0=%b cs1=%b expected dis=%b adr=%b",
                   m, w, RAMDIS, ramadr_hi, ramcs0_b, ramcs1_b, exp_dis,
                   exp_dis ? adrv[m] : 5'b0);
        end
      end
    end
    // Memory request idle: window still owned but neither SRAM selected.
    MREQ_B = 1'b1;
    {A15, A14} = 2'b01;
    #1;
    n_cmp++;
    if (RAMDIS !== 1'b1 || ramcs0_b !== 1'b1 || ramcs1_b !== 1'b1) begin
      n_err++;
      $display("FAIL mreq_idle: dis=%b cs0=%b cs1=%b expected 1 1 1", RAMDIS, ramcs0_b, ramcs1_b);
    end
  endtask

  task automatic test_non_hit();
    int p;
    // D[7:6]=10 is not the RAM-config port.
    do_write(1'b0, 8'h80, 3, p);
    n_cmp++;
    if (p !== 0 || cfg_q !== 8'h87) begin
      n_err++;
      $display("FAIL nohit_d76: pulses=%0d cfg=%h expected 0 87", p, cfg_q);
    end
    // A15=1 is outside the port decode.
    p = 0;
    A15 = 1'b1; A8 = 1'b0; D = 8'hC0; IOREQ_B = 1'b0; WR_B = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (cfg_wr === 1'b1) p++;
    end
    IOREQ_B = 1'b1; WR_B = 1'b1;
    step();
    n_cmp++;
    if (p !== 0 || cfg_q !== 8'h87) begin
      n_err++;
      $display("FAIL nohit_a15: pulses=%0d cfg=%h expected 0 87", p, cfg_q);
    end
  endtask

  // Memory cycle overlapping a port write: old map holds until after the commit edge.
  task automatic test_back_to_back();
    int p;
    do_write(1'b0, 8'hFA, 2, p);
    MREQ_B = 1'b0;
    A15 = 1'b0; A14 = 1'b1; A8 = 1'b1; D = 8'hC0;
    IOREQ_B = 1'b0; WR_B = 1'b0;
    step();
    n_cmp++;
    if (RAMDIS !== 1'b1 || ramcs0_b !== 1'b0 || ramadr_hi !== 5'b11101 || cfg_wr !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_old: dis=%b cs0=%b adr=%b wr=%b expected 1 0 11101 0",
               RAMDIS, ramcs0_b, ramadr_hi, cfg_wr);
    end
    step();
    n_cmp++;
    if (RAMDIS !== 1'b0 || ramcs0_b !== 1'b1 || ramcs1_b !== 1'b1 || cfg_wr !== 1'b1 || cfg_q !== 8'h80) begin
      n_err++;
      $display("FAIL b2b_new: dis=%b cs=%b%b wr=%b cfg=%h expected 0 11 1 80",
               RAMDIS, ramcs0_b, ramcs1_b, cfg_wr, cfg_q);
    end
    IOREQ_B = 1'b1; WR_B = 1'b1; MREQ_B = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset_mid_strobe();
    int p;
    p = 0;
    A15 = 1'b0; A8 = 1'b1; D = 8'hFF; IOREQ_B = 1'b0; WR_B = 1'b0;
    step();               // now in FILTER
    RESET_B = 1'b0;
    step();
    if (cfg_wr === 1'b1) p++;
    RESET_B = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (cfg_wr === 1'b1) p++;
    end
    n_cmp++;
    if (p !== 0 || cfg_q !== 8'h00) begin
      n_err++;
      $display("FAIL rst_mid: pulses=%0d cfg=%h expected 0 00", p, cfg_q);
    end
    IOREQ_B = 1'b1; WR_B = 1'b1;
    step();
    do_write(1'b0, 8'hC9, 2, p);
    n_cmp++;
    if (p !== 1 || cfg_q !== 8'h09) begin
      n_err++;
      $display("FAIL rst_fresh: pulses=%0d cfg=%h expected 1 09", p, cfg_q);
    end
  endtask

  initial begin
    test_reset();
    test_filtered_write();
    test_glitch();
    test_long_strobe();
    test_mode2_sweep();
    test_map_modes();
    test_non_hit();
    test_back_to_back();
    test_reset_mid_strobe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
